// File: rtl/alu_rr_scheduler_pkg.sv
// Shared constants for the ALU round-robin scheduler: opcodes, flag bit
// positions within a 4-bit flag nibble, and the ALU pipeline depth.
package alu_sched_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  localparam logic [1:0] FLAG_SLT   = 2'd3;
  localparam logic [1:0] FLAG_ZERO  = 2'd2;
  localparam logic [1:0] FLAG_CARRY = 2'd1;
  localparam logic [1:0] FLAG_OVF   = 2'd0;

  localparam int unsigned ALU_LATENCY = 1;

  // Next index after idx in a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr,
// wrapping around N_REQ.
module rr_pick
  import alu_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_vld
);

  logic [ID_W-1:0] idx;

  // Scan from rr_ptr upward; the first hit wins and later hits are ignored.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ID_W'((32'(rr_ptr) + k) % N_REQ);
      if (!grant_vld && elig[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one 1-cycle-latency 4-bit ALU among N_REQ
// requesters. Issues at most one op per cycle, tracks the in-flight tag and
// parks each result in a per-requester response slot with backpressure.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [4*N_REQ-1:0] req_a,
  input  logic [4*N_REQ-1:0] req_b,
  input  logic [3*N_REQ-1:0] req_op,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [4*N_REQ-1:0] rsp_result,
  output logic [4*N_REQ-1:0] rsp_flags,
  output logic               alu_in_valid,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [2:0]         alu_op,
  input  logic               alu_out_valid,
  input  logic [3:0]         alu_result,
  input  logic               alu_slt,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               alu_ovf,
  output logic               proto_err
);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  inflight_id;
  logic             inflight_vld;
  logic [N_REQ-1:0] slot_full;
  logic [N_REQ-1:0] busy;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_vld;
  logic [ID_W-1:0]  next_ptr;
  logic [3:0]       flags_in;
  logic             capture;

  // A requester is busy while its op is in flight or its slot is occupied;
  // both terms are registered so rsp_ready never reaches the issue path.
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      busy[i] = slot_full[i] | (inflight_vld & (inflight_id == ID_W'(i)));
    end
    elig = req_valid & ~busy;
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .elig      (elig),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  // Drive the ALU issue port from the granted requester, zeros when idle.
  always_comb begin
    req_ready    = grant;
    alu_in_valid = grant_vld;
    alu_a        = '0;
    alu_b        = '0;
    alu_op       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        alu_a  = req_a[4*i +: 4];
        alu_b  = req_b[4*i +: 4];
        alu_op = req_op[3*i +: 3];
      end
    end
    next_ptr = ID_W'(wrap_inc(32'(grant_id), N_REQ));
  end

  // Pack the ALU flags and decide whether this cycle's result is accepted.
  always_comb begin
    flags_in             = '0;
    flags_in[FLAG_SLT]   = alu_slt;
    flags_in[FLAG_ZERO]  = alu_zero;
    flags_in[FLAG_CARRY] = alu_carry;
    flags_in[FLAG_OVF]   = alu_ovf;
    capture              = alu_out_valid & inflight_vld;
  end

  // Pointer advance and one-deep tag stage matching the ALU latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      inflight_vld <= 1'b0;
      inflight_id  <= '0;
    end else begin
      inflight_vld <= grant_vld;
      if (grant_vld) begin
        inflight_id <= grant_id;
        rr_ptr      <= next_ptr;
      end
    end
  end

  // Response slots: release on handshake, fill on a tagged ALU result.
  // A slot being filled is never full, so capture and release cannot collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full  <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (slot_full[i] && rsp_ready[i]) begin
          slot_full[i] <= 1'b0;
        end
        if (capture && (inflight_id == ID_W'(i))) begin
          slot_full[i]         <= 1'b1;
          rsp_result[4*i +: 4] <= alu_result;
          rsp_flags[4*i +: 4]  <= flags_in;
        end
      end
    end
  end

  // Sticky flag for a result without a tag or a tag without a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
    end else if (alu_out_valid != inflight_vld) begin
      proto_err <= 1'b1;
    end
  end

  assign rsp_valid = slot_full;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a 1-cycle behavioural ALU.
module tb_alu_rr_scheduler;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4*N-1:0] req_a, req_b, rsp_result, rsp_flags;
  logic [3*N-1:0] req_op;
  logic           alu_in_valid, alu_out_valid, proto_err;
  logic [3:0]     alu_a, alu_b, alu_result;
  logic [2:0]     alu_op;
  logic           alu_slt, alu_zero, alu_carry, alu_ovf;

  logic           inject, suppress;
  logic           alu_vld_q;
  logic [3:0]     alu_res_q, alu_flg_q;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.N_REQ(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_op        (req_op),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_flags     (rsp_flags),
    .alu_in_valid  (alu_in_valid),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_out_valid (alu_out_valid),
    .alu_result    (alu_result),
    .alu_slt       (alu_slt),
    .alu_zero      (alu_zero),
    .alu_carry     (alu_carry),
    .alu_ovf       (alu_ovf),
    .proto_err     (proto_err)
  );

  // Behavioural ALU: returns {result, slt, zero, carry, ovf}.
  function automatic logic [7:0] alu_eval(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v, lt;
    s  = '0;
    c  = 1'b0;
    v  = 1'b0;
    lt = ($signed(a) < $signed(b));
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      3'b001: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = {3'b000, lt};
      default: r = 4'd0;
    endcase
    return {r, lt, (r == 4'd0), c, v};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_vld_q <= 1'b0;
      alu_res_q <= '0;
      alu_flg_q <= '0;
    end else begin
      alu_vld_q              <= alu_in_valid;
      {alu_res_q, alu_flg_q} <= alu_eval(alu_a, alu_b, alu_op);
    end
  end

  assign alu_out_valid = (alu_vld_q & ~suppress) | inject;
  assign alu_result    = alu_res_q;
  assign {alu_slt, alu_zero, alu_carry, alu_ovf} = alu_flg_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; inject = 1'b0; suppress = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rr_exp [8];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
    inject = 1'b0; suppress = 1'b0;

    // Reset then idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_alu_in_valid", alu_in_valid, 0);
    check_eq("rst_alu_a", alu_a, 0);
    check_eq("rst_alu_b", alu_b, 0);
    check_eq("rst_alu_op", alu_op, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_result", rsp_result, 0);
    check_eq("rst_rsp_flags", rsp_flags, 0);
    check_eq("rst_proto_err", proto_err, 0);
    check_eq("rst_rr_ptr", dut.rr_ptr, 0);

    // Req0 ADD 7+1 = 8, flags 0001
    @(negedge clk);
    req_valid = 4'b0001; req_a[3:0] = 4'd7; req_b[3:0] = 4'd1; req_op[2:0] = 3'b000; #1;
    check_eq("add_req_ready", req_ready, 4'b0001);
    check_eq("add_in_valid", alu_in_valid, 1);
    check_eq("add_alu_a", alu_a, 7);
    check_eq("add_alu_b", alu_b, 1);
    check_eq("add_alu_op", alu_op, 0);
    @(negedge clk); req_valid = '0; #1;
    check_eq("add_rsp_early", rsp_valid, 0);
    check_eq("add_rr_ptr", dut.rr_ptr, 1);
    @(negedge clk); #1;
    check_eq("add_rsp_valid", rsp_valid, 4'b0001);
    check_eq("add_result", rsp_result[3:0], 8);
    check_eq("add_flags", rsp_flags[3:0], 4'b0001);
    rsp_ready = 4'b0001;
    @(negedge clk); #1;
    check_eq("add_released", rsp_valid, 0);
    check_eq("add_data_hold", rsp_result[3:0], 8);
    rsp_ready = '0;

    // All four continuously valid, responses always consumed
    do_reset();
    rsp_ready = 4'b1111;
    req_a = {4'd4, 4'd3, 4'd2, 4'd1}; req_b = '0; req_op = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 4'b1111;
      #1;
      check_eq($sformatf("rr_grant%0d", k), req_ready, rr_exp[k]);
      check_eq($sformatf("rr_alu_a%0d", k), alu_a, (k % 4) + 1);
      if (k == 4) check_eq("rr_ptr_wrap", dut.rr_ptr, 0);
    end
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rr_drained", rsp_valid, 0);
    check_eq("rr_no_err", proto_err, 0);

    // Req2 SLT -8 < 1 held under backpressure, then ADD 3+2 waits for release
    rsp_ready = '0;
    @(negedge clk);
    req_valid = 4'b0100; req_a[11:8] = 4'b1000; req_b[11:8] = 4'b0001; req_op[8:6] = 3'b101; #1;
    check_eq("slt_grant", req_ready, 4'b0100);
    check_eq("slt_alu_op", alu_op, 3'b101);
    @(negedge clk);
    req_a[11:8] = 4'd3; req_b[11:8] = 4'd2; req_op[8:6] = 3'b000; #1;
    check_eq("slt_inflight_block", req_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check_eq($sformatf("slt_hold_valid%0d", k), rsp_valid, 4'b0100);
      check_eq($sformatf("slt_hold_result%0d", k), rsp_result[11:8], 1);
      check_eq($sformatf("slt_hold_flags%0d", k), rsp_flags[11:8], 4'b1000);
      check_eq($sformatf("slt_hold_block%0d", k), req_ready, 0);
    end
    @(negedge clk); rsp_ready = 4'b0100; #1;
    check_eq("slt_release_cycle", req_ready, 0);
    @(negedge clk); rsp_ready = '0; #1;
    check_eq("slt_regrant", req_ready, 4'b0100);
    check_eq("slt_regrant_a", alu_a, 3);
    check_eq("slt_slot_empty", rsp_valid, 0);
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    check_eq("add2_valid", rsp_valid, 4'b0100);
    check_eq("add2_result", rsp_result[11:8], 5);
    check_eq("add2_flags", rsp_flags[11:8], 4'b0000);
    rsp_ready = 4'b0100;

    // Result with no tag in flight
    @(negedge clk); rsp_ready = '0; inject = 1'b1;
    @(negedge clk); inject = 1'b0; #1;
    check_eq("orphan_err", proto_err, 1);
    check_eq("orphan_no_slot", rsp_valid, 0);
    check_eq("orphan_slot_data", rsp_result[11:8], 5);
    repeat (3) @(negedge clk);
    #1;
    check_eq("orphan_sticky", proto_err, 1);

    // Tag in flight with no result
    do_reset();
    #1;
    check_eq("err_cleared", proto_err, 0);
    @(negedge clk);
    suppress = 1'b1; req_valid = 4'b0010; req_a[7:4] = 4'd5; req_b[7:4] = 4'd5; req_op[5:3] = 3'b000; #1;
    check_eq("lost_grant", req_ready, 4'b0010);
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    check_eq("lost_err", proto_err, 1);
    check_eq("lost_no_slot", rsp_valid, 0);

    // Reset the cycle after a grant
    do_reset();
    rsp_ready = 4'b1111;
    @(negedge clk);
    req_valid = 4'b1000; req_a[15:12] = 4'd1; req_b[15:12] = 4'd1; req_op[11:9] = 3'b000; #1;
    check_eq("mid_grant", req_ready, 4'b1000);
    @(negedge clk); req_valid = '0; rst_n = 1'b0; #1;
    check_eq("mid_tag_clear", dut.inflight_vld, 0);
    check_eq("mid_slots_clear", rsp_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check_eq($sformatf("mid_no_rsp%0d", k), rsp_valid, 0);
    end
    check_eq("mid_no_err", proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Round-robin scheduler that shares the single 1-cycle-latency 4-bit pipelined ALU among `N_REQ` requesters. It accepts operations over per-requester valid/ready handshakes and issues at most one per cycle to the ALU. It tracks the in-flight requester tag and returns each result and flag set through a per-requester response slot with backpressure. It sits between the requesting datapath blocks and the ALU's `in_valid/A/B/OpCode` and `out_valid/Result/flags` ports.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ID_W`, `$clog2(N_REQ)`, requester tag width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  request present, one bit per requester
- `req_ready`  out  N_REQ  request accepted this cycle (one-hot or zero)
- `req_a`, `req_b`  in  4*N_REQ  operands; requester i occupies bits [4i+3:4i]
- `req_op`  in  3*N_REQ  opcode; requester i occupies bits [3i+2:3i]
- `rsp_valid`  out  N_REQ  response slot i holds a result
- `rsp_ready`  in  N_REQ  requester i consumes its response
- `rsp_result`  out  4*N_REQ  result per requester
- `rsp_flags`  out  4*N_REQ  per requester: {SLT, Zero, Carry, Overflow}
- `alu_in_valid`  out  1  issue strobe to the ALU
- `alu_a`, `alu_b`  out  4  ALU operands
- `alu_op`  out  3  ALU opcode
- `alu_out_valid`  in  1  ALU result strobe
- `alu_result`  in  4  ALU result
- `alu_slt`, `alu_zero`, `alu_carry`, `alu_ovf`  in  1 each  ALU flags
- `proto_err`  out  1  sticky ALU-protocol violation

## Operation
- Busy rule: `busy[i]` is set when the in-flight tag belongs to i or `slot_full[i]` is set. Both terms come from registered state only.
- Eligibility: `elig[i] = req_valid[i] & ~busy[i]`.
  - Each requester has at most one operation outstanding, counting both in flight and waiting in its slot.
- Pick: choose the first eligible index at or after `rr_ptr`, wrapping modulo N_REQ.
  - On a grant to g: `req_ready[g]=1` and `alu_in_valid=1`.
  - On a grant, `alu_a/alu_b/alu_op` carry requester g's fields and `rr_ptr <= (g+1) mod N_REQ`.
- No grant: `alu_in_valid=0`, `alu_a/alu_b/alu_op` driven to 0, and `rr_ptr` holds.
- Tag stage: `inflight_vld <= grant` and `inflight_id <= g`.
- Capture: when `alu_out_valid & inflight_vld`, write the result and flags into slot `inflight_id` and set `slot_full`.
- Release: `rsp_valid[i] & rsp_ready[i]` clears `slot_full[i]` at the next edge.
  - Slot data holds until it is overwritten by that requester's next result.
- Same-cycle release and request: no regrant in that cycle, because busy is registered. The grant happens in the next cycle.
- Protocol error: `proto_err` sets and stays set until reset when either of these occurs:
  - `alu_out_valid` is high while `inflight_vld` is low. The result is dropped.
  - `inflight_vld` is high while `alu_out_valid` is low. The tag is dropped.
- Opcodes are passed through unchanged. Codes 110/111 are issued as-is, and the ALU returns 0 with Zero=1.

## Timing
- Reset values:
  - `req_ready=0`, `alu_in_valid=0`, `alu_a/b/op=0`.
  - `rsp_valid=0`, `rsp_result=0`, `rsp_flags=0`, `proto_err=0`.
  - `rr_ptr=0`, `inflight_vld=0`.
- `req_ready` and the `alu_*` issue outputs are combinational from `req_valid` and registered state. There is no combinational path from `alu_*` inputs or `rsp_ready` to them.
- Latency from grant edge to `rsp_valid` is 2 cycles:
  - Grant at cycle c.
  - ALU result at c+1.
  - `rsp_valid` high at c+2.
- Single-requester throughput: with `rsp_ready` held high, one op per 3 cycles.
- Aggregate throughput: one op per cycle across distinct requesters.
- Reset mid-operation clears the tag and all slots immediately. The ALU shares `rst_n`, so no stale result follows.

## Structure
- Package `alu_sched_pkg` holds:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_SLT=101;
  - flag bit indices FLAG_SLT=3, FLAG_ZERO=2, FLAG_CARRY=1, FLAG_OVF=0;
  - `ALU_LATENCY=1`.
- Sub-module `rr_pick`: combinational priority rotation. It takes `elig[N_REQ]` and `rr_ptr` and returns a one-hot grant plus the index.
- The pointer register and tag/slot state stay in the top level.

## Test plan
- Reset then idle: all outputs are 0 and `rr_ptr=0`.
- Req0 ADD A=7, B=1: `req_ready[0]` and `alu_in_valid` are high in the same cycle.
  - The bench ALU returns 8, Carry=0, Ovf=1.
  - `rsp_valid[0]` rises 2 cycles after the grant with `rsp_result[0]=8` and flags=0001.
- All four requesters valid continuously with `rsp_ready=1111`: grants go 0,1,2,3, one per cycle.
  - Each requester's next grant comes only after its slot is released.
  - No starvation; `rr_ptr` wraps 3→0.
- Req2 SLT A=1000, B=0001 with `rsp_ready[2]=0` for 5 cycles: result 1 and flags=1000 are held.
  - A new `req_valid[2]` is not granted until 1 cycle after `rsp_ready[2]` is asserted.
- Bench ALU pulses `alu_out_valid` with no issue: `proto_err` goes to 1, no slot changes, and it stays 1 until `rst_n` is asserted.
- `rst_n` asserted the cycle after a grant: all slots and the tag are cleared, and no `rsp_valid` appears after release.
